// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive path.
//   - FSM state encoding (3-bit IDLE..STOP) and the enum built on it
//   - parity type constants for PAR_TYP
//   - the supported oversampling ratios for Prescale
package uart_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = IDLE,
    ST_START  = START,
    ST_DATA   = DATA,
    ST_PARITY = PARITY,
    ST_STOP   = STOP
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int PRESC_8  = 8;
  localparam int PRESC_16 = 16;
  localparam int PRESC_32 = 32;

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// uart_rx_deserializer_if: serial input, frame configuration and received-word
// outputs of the UART receiver, bundled as one interface.
//   master : line/config driver side (drives RX_IN, Prescale, PAR_EN, PAR_TYP)
//   slave  : receiver side (drives P_DATA, data_valid, par_err, stp_err)
interface uart_rx_deserializer_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
);
  logic                      RX_IN;
  logic [PRESCALE_WIDTH-1:0] Prescale;
  logic                      PAR_EN;
  logic                      PAR_TYP;
  logic [DATA_WIDTH-1:0]     P_DATA;
  logic                      data_valid;
  logic                      par_err;
  logic                      stp_err;

  modport master (
    output RX_IN, Prescale, PAR_EN, PAR_TYP,
    input  P_DATA, data_valid, par_err, stp_err
  );

  modport slave (
    input  RX_IN, Prescale, PAR_EN, PAR_TYP,
    output P_DATA, data_valid, par_err, stp_err
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: front end of the UART receiver.
//   Synchronizes RX_IN into rx_s, runs the per-bit oversampling counter and
//   produces the bit decision.
// Ports:
//   clk, rst_n   clock / async active-low reset
//   rx_in        raw asynchronous serial line
//   prescale     oversampling ratio
//   active       FSM is not idle (enables strobes and counting)
//   cnt_clr      FSM returns to idle next cycle; restart the counter
//   rx_s         synchronized line
//   sampled_bit  bit value valid while decision is high
//   decision     one-cycle strobe at the decision point of a bit
//   bit_end      one-cycle strobe on the last oversampling tick of a bit
// Build option: UART_RX_MAJORITY_VOTE_EN selects 2-of-3 voting over the
// ticks Prescale/2-1, Prescale/2, Prescale/2+1 (decision at Prescale/2+1);
// otherwise a single sample is taken at Prescale/2.
module uart_rx_sampler #(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx_in,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      active,
  input  logic                      cnt_clr,
  output logic                      rx_s,
  output logic                      sampled_bit,
  output logic                      decision,
  output logic                      bit_end
);

  logic                      rx_meta;
  logic [PRESCALE_WIDTH-1:0] edge_cnt;
  logic [PRESCALE_WIDTH-1:0] presc_m1;
  logic [PRESCALE_WIDTH-1:0] half;

  assign presc_m1 = prescale - 1'b1;
  assign half     = prescale >> 1;

  // Two-flop synchronizer; line idles high, so reset to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  assign bit_end = active && (edge_cnt == presc_m1);

  // Wraps at Prescale-1; any ratio (even unsupported ones) reaches the wrap
  // point, so bit_end always fires eventually.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
    end else if (!active || cnt_clr || bit_end) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_cnt + 1'b1;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic s_early;
  logic s_mid;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_early <= 1'b1;
      s_mid   <= 1'b1;
    end else begin
      if (active && (edge_cnt == half - 1'b1)) s_early <= rx_s;
      if (active && (edge_cnt == half))        s_mid   <= rx_s;
    end
  end

  // Third vote is the live synchronized line at the decision tick.
  assign sampled_bit = maj3(s_early, s_mid, rx_s);
  assign decision    = active && (edge_cnt == half + 1'b1);
`else
  assign sampled_bit = rx_s;
  assign decision    = active && (edge_cnt == half);
`endif

endmodule

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: UART receive path. Oversamples RX_IN at Prescale x
// baud, checks start/parity/stop bits and rebuilds the LSB-first data word.
// Ports:
//   clk     oversampling clock
//   rst_n   async active-low reset
//   rx_if   slave modport of uart_rx_deserializer_if:
//             in : RX_IN, Prescale, PAR_EN, PAR_TYP
//             out: P_DATA (last good word), data_valid / par_err / stp_err
//                  (one-cycle pulses)
// Build option: UART_RX_MAJORITY_VOTE_EN (see uart_rx_sampler) moves the
// decision point to Prescale/2+1 with 2-of-3 voting.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input logic                   clk,
  input logic                   rst_n,
  uart_rx_deserializer_if.slave rx_if
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH - 1);

  rx_state_e             state;
  rx_state_e             state_nxt;
  logic [BCW-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  frame_err;
  logic                  data_valid_r;
  logic                  par_err_r;
  logic                  stp_err_r;

  logic                  dv_nxt;
  logic                  pe_nxt;
  logic                  se_nxt;
  logic                  load;
  logic                  exp_par;

  logic                  rx_s;
  logic                  sampled_bit;
  logic                  decision;
  logic                  bit_end;
  logic                  active;
  logic                  cnt_clr;

  assign active  = (state != ST_IDLE);
  assign cnt_clr = (state_nxt == ST_IDLE);
  assign exp_par = (^shift_reg) ^ rx_if.PAR_TYP;

  uart_rx_sampler #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_sampler (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_in       (rx_if.RX_IN),
    .prescale    (rx_if.Prescale),
    .active      (active),
    .cnt_clr     (cnt_clr),
    .rx_s        (rx_s),
    .sampled_bit (sampled_bit),
    .decision    (decision),
    .bit_end     (bit_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dv_nxt    = 1'b0;
    pe_nxt    = 1'b0;
    se_nxt    = 1'b0;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rx_s) state_nxt = ST_START;
      end
      ST_START: begin
        // A start bit that reads high mid-bit was only a glitch.
        if (decision && sampled_bit) begin
          state_nxt = ST_IDLE;
        end else if (bit_end) begin
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end && (bit_cnt == BIT_LAST)) begin
          state_nxt = rx_if.PAR_EN ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (decision && (sampled_bit != exp_par)) pe_nxt = 1'b1;
        if (bit_end) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        // Leave at mid-stop so a back-to-back start edge is not missed.
        if (decision) begin
          state_nxt = ST_IDLE;
          if (!sampled_bit) begin
            se_nxt = 1'b1;
          end else if (!frame_err) begin
            dv_nxt = 1'b1;
            load   = 1'b1;
          end
        end else if (bit_end) begin
          // Only reachable for ratios whose decision tick never occurs.
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (state != ST_DATA) begin
      bit_cnt <= '0;
    end else if (bit_end) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
    end else if ((state == ST_DATA) && decision) begin
      shift_reg[bit_cnt] <= sampled_bit;
    end
  end

  // Parity failure is remembered until the frame ends so STOP can suppress
  // data_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
    end else if (state == ST_IDLE) begin
      frame_err <= 1'b0;
    end else if (pe_nxt) begin
      frame_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_data       <= '0;
      data_valid_r <= 1'b0;
      par_err_r    <= 1'b0;
      stp_err_r    <= 1'b0;
    end else begin
      if (load) p_data <= shift_reg;
      data_valid_r <= dv_nxt;
      par_err_r    <= pe_nxt;
      stp_err_r    <= se_nxt;
    end
  end

  assign rx_if.P_DATA     = p_data;
  assign rx_if.data_valid = data_valid_r;
  assign rx_if.par_err    = par_err_r;
  assign rx_if.stp_err    = stp_err_r;

endmodule
